// File: rtl/cnn_pkg.sv
// Shared definitions for the 1D CNN datapath: default widths and the unsigned
// max helper used by the pooling stage.
package cnn_pkg;

  localparam int CONV_W = 10;
  localparam int POOL_P = 2;

  function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_fifo.sv
// First-word-fall-through FIFO holding pooled values; the head is always
// presented on dout, and the storage array is left unreset.
module pool_fifo
  import cnn_pkg::*;
#(
  parameter int W     = CONV_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/maxpool_1d.sv
// 1D max pooling (window and stride P) over the convolution result stream,
// with pooled values buffered in a small FWFT FIFO drained by valid/ready.
module maxpool_1d
  import cnn_pkg::*;
#(
  parameter int W     = CONV_W,
  parameter int P     = POOL_P,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InValid,
  input  logic [W-1:0] InData,
  input  logic         InLast,
  output logic         InReady,
  output logic         OutValid,
  output logic [W-1:0] OutData,
  input  logic         OutReady,
  output logic         Overflow
);

  localparam int            CW       = $clog2(P);
  localparam int            NW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(P - 1);

  logic [CW-1:0] win_cnt_p0;
  logic [W-1:0]  acc_p0;
  logic          overflow_p0;

  logic          accept;
  logic          first_elem;
  logic          close_win;
  logic          take_new;
  logic [W-1:0]  win_max;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [NW-1:0] fifo_count;
  logic [W-1:0]  fifo_dout;

  assign accept     = InValid & InReady;
  assign first_elem = (win_cnt_p0 == '0);
  assign close_win  = accept & ((win_cnt_p0 == LAST_IDX) | InLast);
  // Select rather than compute, so the pooled value is always an input sample.
  assign take_new   = (umax(32'(acc_p0), 32'(InData)) == 32'(InData));
  assign win_max    = (first_elem | take_new) ? InData : acc_p0;

  // ---- stage p0: window accumulate / close ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_p0  <= '0;
      acc_p0      <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      if (accept) begin
        acc_p0     <= win_max;
        win_cnt_p0 <= close_win ? '0 : win_cnt_p0 + CW'(1);
      end
      if (InValid & ~InReady) begin
        overflow_p0 <= 1'b1;
      end
    end
  end

  // ---- output buffer ----
  pool_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (close_win),
    .pop   (pop),
    .din   (win_max),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign InReady  = ~fifo_full;
  assign OutValid = (fifo_count != '0);
  assign pop      = OutValid & OutReady;
  assign OutData  = fifo_empty ? '0 : fifo_dout;
  assign Overflow = overflow_p0;

endmodule

// File: doc/maxpool_1d.md
# maxpool_1d

Downstream stage of the 1D single-layer convolution path. Consumes the 10-bit convolution result stream, reduces each window of `P` consecutive results to their maximum (stride `P`), and buffers the pooled values in a small first-word-fall-through FIFO. The consumer drains the FIFO through a valid/ready handshake. `InLast` closes a partial trailing window so row boundaries are respected.

## Interface
- `W`, 10, data width; matches the convolution result width.
- `P`, 2, pool window and stride, with 2 ≤ P ≤ 8.
- `DEPTH`, 4, FIFO entries, power of two, at least 2.
- `clk` input 1: the single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `InValid` input 1: `InData` is valid this cycle.
- `InData` input W: unsigned convolution result.
- `InLast` input 1: qualified by `InValid`; this element closes the current window.
- `InReady` output 1: the stage can accept an element this cycle.
- `OutValid` output 1: `OutData` holds a pooled value.
- `OutData` output W: head of the FIFO; 0 when the FIFO is empty.
- `OutReady` input 1: the consumer takes the head this cycle.
- `Overflow` output 1: sticky; set by an `InValid` while `InReady`=0.

## Operation
- Accept condition: `InValid & InReady`. A pop happens on `OutValid & OutReady`.
- `InReady` = ~FIFO full. It is combinational from the occupancy count only and does not depend on a same-cycle pop.
- Window counter `WinCnt` runs 0..P-1.
  - On an accept with `WinCnt`=0, `Acc` is loaded with `InData`.
  - On any other accept, `Acc` becomes max(`Acc`, `InData`), an unsigned compare.
- Window close: an accept with `WinCnt`=P-1 or `InLast`=1.
  - The closing value max(`Acc`, `InData`) is pushed into the FIFO; on a first-element close it is `InData` alone.
  - `WinCnt` returns to 0.
  - Otherwise `WinCnt` increments.
- `InLast` with `WinCnt`=0 pushes a single-element window, i.e. `InData` unchanged.
- No arithmetic widening: `OutData` = W bits, taken directly from a selected input.
- FIFO:
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy count runs 0..DEPTH.
  - `OutValid` = count≠0.
- Simultaneous push and pop: both take effect and the count is unchanged. This case is legal only when count is between 1 and DEPTH-1, because `InReady`=0 when full.
- A pop is ignored while the FIFO is empty.
- Overflow: an `InValid` with `InReady`=0 is not accepted (upstream must hold it) and sets `Overflow` until reset. Upstream without a stall capability uses this flag to detect lost data.
- Reset, asynchronous, with effect immediate and mid-window included:
  - `WinCnt`=0, `Acc`=0, pointers and count = 0.
  - `OutValid`=0, `OutData`=0, `InReady`=1, `Overflow`=0.
  - A partially accumulated window is discarded. FIFO contents are treated as invalid; the storage array itself needs no reset.

## Timing
- The closing accept at edge k makes its pooled value visible on `OutData` with `OutValid`=1 in the cycle after edge k, provided the FIFO was empty: 1-cycle latency.
- Non-closing accepts produce no output.
- A pop at edge k presents the next entry, or `OutValid`=0, after edge k.
- `InReady` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- Throughput: one input per cycle, sustained while the consumer holds `OutReady`=1.

## Structure
- Shared package `cnn_pkg`:
  - `CONV_W` = 10, the default for `W`.
  - `POOL_P` = 2, the default for `P`.
  - The function `umax(a,b)`.
- One sub-module, `pool_fifo`: a parameterised `W`×`DEPTH` first-word-fall-through FIFO with push, pop, full, empty and count.
- The window logic (`Acc`, `WinCnt`, close detect) lives in `maxpool_1d` itself.

## Test plan
- **Reset:** assert `reset` mid-window after accepting 7, then release and send 3, 9 → no 7 is ever output; the FIFO receives 9; all outputs read 0/0/1/0 during reset.
- **Basic pooling** (P=2, `OutReady`=1): send 5, 12, 1023, 0, 4, 4 → `OutData` sequence 12, 1023, 4, each valid one cycle after the pair's second accept.
- **Partial window:** send 8, 3, 6 with `InLast` on 6 → outputs 8 then 6. Next send 2, 9 → output 9, confirming the window restarts at 0.
- **Backpressure and full:** `OutReady`=0, send 8 pairs → after 4 pooled values `InReady`=0. Hold `InValid` with value 77 → `Overflow`=1 and the FIFO is unchanged. Raise `OutReady` → four values drain in order, and `InReady` returns 1 one cycle after the first pop.
- **Simultaneous push and pop:** with count=2, a closing accept coinciding with a pop keeps count at 2 and preserves order.
- **Pointer wrap:** stream 20 pairs with `OutReady` toggling 1,0 each cycle → every pooled value is received exactly once, in order, with no `Overflow`.
